// File: rtl/armleo_burst_mux.sv
// Burst-locking N-to-1 mux placed behind an external round-robin arbiter.
// Optional burst-length cap: define ARMLEO_BURST_MUX_MAXBURST_EN (adds MAX_BURST, burst_trunc).
module armleo_burst_mux #(
    parameter int WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
    , parameter int MAX_BURST = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            in_valid,
    output logic [WIDTH-1:0]            in_ready,
    input  logic [WIDTH*DATA_WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0]            in_last,
    output logic [WIDTH-1:0]            arb_request,
    input  logic [WIDTH-1:0]            arb_grant,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    output logic [SEL_W-1:0]            out_sel
`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
    , output logic                      burst_trunc
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_next;
    logic [SEL_W-1:0] sel, sel_next;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic             accept;
    logic             beat_last;

    // Descending scan so the lowest set grant bit is the one that sticks.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (arb_grant[i-1]) begin
                grant_idx = SEL_W'(i - 1);
                grant_any = 1'b1;
            end
        end
    end

    assign accept = in_valid[sel] & in_ready[sel];

`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] beat_cnt;
    logic             force_last;

    assign force_last = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign beat_last  = in_last[sel] | force_last;

    // Held at zero while idle, so every lock starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_trunc <= 1'b0;
        end else begin
            burst_trunc <= accept & force_last & ~in_last[sel];
        end
    end
`else
    assign beat_last = in_last[sel];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        if (state == IDLE) begin
            if (grant_any) begin
                state_next = LOCKED;
                sel_next   = grant_idx;
            end
        end else if (accept && beat_last) begin
            state_next = IDLE;
        end
    end

    // Requests are withheld while locked so the arbiter's rotation stays frozen.
    always_comb begin
        arb_request = '0;
        in_ready    = '0;
        if (rst_n) begin
            if (state == IDLE) begin
                arb_request = in_valid;
            end else begin
                in_ready[sel] = ~out_valid | out_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[sel*DATA_WIDTH +: DATA_WIDTH];
            out_last  <= beat_last;
            out_sel   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_armleo_burst_mux.sv
// Bench for armleo_burst_mux: bench-side round-robin arbiter, queue-based reference model,
// directed scenarios with literal expectations plus a randomized traffic phase.
`timescale 1ns/1ps
module tb_armleo_burst_mux;
    localparam int W  = 4;
    localparam int DW = 32;
`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
    localparam int MAXB = 4;
`else
    localparam int MAXB = 1 << 30;
`endif

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [DW-1:0] data; logic last; int sel; logic trunc; } obeat_t;
    typedef struct { int cyc; int sel; logic [DW-1:0] data; logic last; logic trunc; } log_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W-1:0]    in_valid = '0;
    logic [W-1:0]    in_last = '0;
    logic [W*DW-1:0] in_data = '0;
    logic [W-1:0]    in_ready, arb_request, arb_grant;
    logic            out_valid, out_last;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            trunc_obs;

    armleo_burst_mux #(
        .WIDTH(W),
        .DATA_WIDTH(DW)
`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
        , .MAX_BURST(MAXB)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .arb_request(arb_request), .arb_grant(arb_grant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sel(out_sel)
`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
        , .burst_trunc(trunc_obs)
`endif
    );
`ifndef ARMLEO_BURST_MUX_MAXBURST_EN
    assign trunc_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [W-1:0] v);
        int r = -1;
        for (int k = W - 1; k >= 0; k--) if (v[k]) r = k;
        return r;
    endfunction

    // Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
    logic [1:0]   rr_ptr;
    logic [W-1:0] rr_grant;
    logic [W-1:0] gnt_ovr = '0;
    always_comb begin
        rr_grant = '0;
        for (int k = 0; k < W; k++)
            if (rr_grant == '0 && arb_request[(int'(rr_ptr) + k) % W]) rr_grant[(int'(rr_ptr) + k) % W] = 1'b1;
    end
    assign arb_grant = (gnt_ovr != '0) ? gnt_ovr : rr_grant;
    always @(posedge clk) begin
        if (!rst_n) rr_ptr <= 2'd0;
        else if (arb_grant != '0) rr_ptr <= 2'((lowest(arb_grant) + 1) % W);
    end

    // Source queues and output-ready control.
    beat_t        srcq[W][$];
    logic [W-1:0] acc_mask = '0;
    int           acc_cnt[W];
    int           rdy_mode = 0;
    int           pat_i = 0;
    logic         rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < W; k++) begin
                if (acc_mask[k] && srcq[k].size() != 0) srcq[k].delete(0);
                if (srcq[k].size() != 0) begin
                    in_valid[k] = 1'b1;
                    in_data[k*DW +: DW] = srcq[k][0].data;
                    in_last[k] = srcq[k][0].last;
                end else begin
                    in_valid[k] = 1'b0;
                    in_last[k]  = 1'b0;
                end
            end
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(3) != 0);
                default: begin out_ready = rdy_pat[pat_i % 4]; pat_i++; end
            endcase
        end
    end

    // Reference model: locked channel (or -1), beat count in the lock, one-deep output queue.
    int     m_ch = -1;
    int     m_cnt = 0;
    obeat_t m_q[$];
    logic   m_fresh = 1'b0;
    log_t   log_q[$];
    int     gnt_q[$];

    always @(negedge clk) begin
        logic [W-1:0] e_req, e_rdy;
        logic acc, lst, frc;
        obeat_t ob;
        e_req = '0;
        e_rdy = '0;
        if (rst_n && m_ch < 0) e_req = in_valid;
        if (rst_n && m_ch >= 0 && (m_q.size() == 0 || out_ready)) e_rdy[m_ch] = 1'b1;
        check("arb_request", arb_request, e_req);
        check("in_ready", in_ready, e_rdy);
        check("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("out_data", out_data, m_q[0].data);
            check("out_last", out_last, m_q[0].last);
            check("out_sel", out_sel, m_q[0].sel);
        end
`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
        check("burst_trunc", trunc_obs, m_fresh && m_q.size() != 0 && m_q[0].trunc);
`endif
        acc_mask = in_valid & in_ready;
        for (int k = 0; k < W; k++) if (acc_mask[k]) acc_cnt[k]++;
        if (rst_n && out_valid && out_ready)
            log_q.push_back('{cyc, int'(out_sel), out_data, out_last, trunc_obs});
        if (rst_n && arb_request != '0 && arb_grant != '0) gnt_q.push_back(cyc);

        m_fresh = 1'b0;
        if (!rst_n) begin
            m_ch = -1;
            m_cnt = 0;
            m_q.delete();
        end else begin
            acc = (m_ch >= 0) && in_valid[m_ch] && e_rdy[m_ch];
            if (m_q.size() != 0 && out_ready) m_q.delete(0);
            if (acc) begin
                m_cnt++;
                lst = in_last[m_ch];
                frc = (m_cnt == MAXB);
                ob.data = in_data[m_ch*DW +: DW];
                ob.last = lst || frc;
                ob.sel = m_ch;
                ob.trunc = frc && !lst;
                m_q.push_back(ob);
                m_fresh = 1'b1;
                if (lst || frc) m_ch = -1;
            end else if (m_ch < 0 && arb_grant != '0) begin
                m_ch = lowest(arb_grant);
                m_cnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_burst(input int ch, input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++) srcq[ch].push_back('{base + DW'(i), i == len - 1});
    endtask

    function automatic logic all_empty();
        for (int k = 0; k < W; k++) if (srcq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        logic done;
        done = all_empty() && !out_valid && m_ch < 0;
        while (!done && n < budget) begin
            step(1);
            n++;
            done = all_empty() && !out_valid && m_ch < 0;
        end
        check("idle_timeout", done, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < W; k++) srcq[k].delete();
        step(1);
        rst_n = 1'b1;
        pat_i = 0;
        log_q.delete();
        gnt_q.delete();
    endtask

    initial begin
        int t0, rnd_in, n;
        logic [DW-1:0] exp_c[8];
        int exp_s[8];

        // Reset held 3 cycles with every channel requesting.
        for (int k = 0; k < W; k++) push_burst(k, 2, DW'(32'h100 * k));
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_in_ready", in_ready, 4'b0000);
            check("rst_arb_request", arb_request, 4'b0000);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_sel", out_sel, 2'd0);
        end
        rst_n = 1'b1;
        wait_idle(200);

        // Single channel, 3-beat burst, full throughput.
        do_reset();
        push_burst(2, 3, 32'hA0);
        wait_idle(100);
        check("single_grants", gnt_q.size() >= 1, 1'b1);
        check("single_beats", log_q.size(), 3);
        if (gnt_q.size() >= 1 && log_q.size() == 3) begin
            t0 = gnt_q[0];
            for (int i = 0; i < 3; i++) begin
                check("single_cycle", log_q[i].cyc, t0 + 2 + i);
                check("single_data", log_q[i].data, 32'hA0 + i);
                check("single_sel", log_q[i].sel, 2);
                check("single_last", log_q[i].last, i == 2);
            end
        end

        // Contention: ch0 and ch3, two 2-beat bursts each.
        do_reset();
        push_burst(0, 2, 32'h00); push_burst(0, 2, 32'h02);
        push_burst(3, 2, 32'h30); push_burst(3, 2, 32'h32);
        wait_idle(200);
        exp_c = '{32'h00, 32'h01, 32'h30, 32'h31, 32'h02, 32'h03, 32'h32, 32'h33};
        exp_s = '{0, 0, 3, 3, 0, 0, 3, 3};
        check("cont_beats", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("cont_sel", log_q[i].sel, exp_s[i]);
                check("cont_data", log_q[i].data, exp_c[i]);
                check("cont_last", log_q[i].last, i % 2 == 1);
            end
            check("cont_inburst_gap", log_q[1].cyc - log_q[0].cyc, 1);
            check("cont_bubble_gap", log_q[2].cyc - log_q[1].cyc, 2);
        end

        // Backpressure: out_ready cycles 1,0,0,1 during a 4-beat ch1 burst.
        do_reset();
        rdy_mode = 2;
        push_burst(1, 4, 32'hB0);
        wait_idle(200);
        rdy_mode = 0;
        check("bp_beats", log_q.size(), 4);
        if (log_q.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("bp_data", log_q[i].data, 32'hB0 + i);
                check("bp_last", log_q[i].last, i == 3);
            end

        // Reset after beat 2 of a 5-beat ch0 burst, then a normal ch1 burst.
        do_reset();
        acc_cnt[0] = 0;
        push_burst(0, 5, 32'hF0);
        n = 0;
        while (acc_cnt[0] < 2 && n < 50) begin step(1); n++; end
        check("mid_reset_reach", acc_cnt[0] >= 2, 1'b1);
        rst_n = 1'b0;
        srcq[0].delete();
        step(1);
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_arb_request", arb_request, 4'b0000);
        rst_n = 1'b1;
        log_q.delete();
        push_burst(1, 2, 32'hC0);
        wait_idle(100);
        check("post_reset_beats", log_q.size(), 2);
        if (log_q.size() == 2)
            for (int i = 0; i < 2; i++) begin
                check("post_reset_sel", log_q[i].sel, 1);
                check("post_reset_data", log_q[i].data, 32'hC0 + i);
            end

        // Multi-hot grant: lowest index wins.
        do_reset();
        push_burst(1, 1, 32'hD1);
        push_burst(2, 1, 32'hD2);
        step(1);
        gnt_ovr = 4'b0110;
        step(1);
        gnt_ovr = 4'b0000;
        wait_idle(100);
        check("multihot_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("multihot_first_sel", log_q[0].sel, 1);
            check("multihot_second_sel", log_q[1].sel, 2);
        end

`ifdef ARMLEO_BURST_MUX_MAXBURST_EN
        // 6-beat ch1 burst against a cap of 4.
        do_reset();
        push_burst(1, 6, 32'hE0);
        wait_idle(100);
        check("trunc_beats", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("trunc_b4_last", log_q[3].last, 1'b1);
            check("trunc_b4_flag", log_q[3].trunc, 1'b1);
            check("trunc_b5_last", log_q[4].last, 1'b0);
            check("trunc_b5_flag", log_q[4].trunc, 1'b0);
            check("trunc_b6_last", log_q[5].last, 1'b1);
            check("trunc_b6_flag", log_q[5].trunc, 1'b0);
            check("trunc_regrant_gap", log_q[4].cyc - log_q[3].cyc, 2);
        end
`endif

        // Randomized traffic with random backpressure.
        do_reset();
        rdy_mode = 1;
        rnd_in = 0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) begin
                int ch, len;
                ch = $urandom_range(W - 1);
                len = $urandom_range(6, 1);
                if (srcq[ch].size() < 8) begin
                    for (int i = 0; i < len; i++) srcq[ch].push_back('{DW'($urandom), i == len - 1});
                    rnd_in += len;
                end
            end
            step(1);
        end
        wait_idle(3000);
        rdy_mode = 0;
        check("random_beat_count", log_q.size(), rnd_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/armleo_burst_mux.md
Name: armleo_burst_mux

Overview:
- N-to-1 burst multiplexer that sits directly downstream of the round-robin arbiter (WIDTH-bit request/grant interface).
- Presents input valids to the arbiter as requests and latches the one-hot grant.
- Locks onto the granted channel until its `last` beat is transferred, and drives a registered valid/ready output stream.
- The arbiter is instantiated externally; this block only drives `arb_request` and consumes `arb_grant`.

Parameters:
- WIDTH, 4, number of input channels; must match the arbiter WIDTH.
- DATA_WIDTH, 32, payload bits per beat.
- SEL_W, $clog2(WIDTH) (localparam), width of the channel index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low; clock clk.
- in_valid  in  WIDTH  per-channel beat valid.
- in_ready  out  WIDTH  per-channel beat accept.
- in_data  in  WIDTH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  WIDTH  per-channel end-of-burst marker.
- arb_request  out  WIDTH  request vector to the arbiter.
- arb_grant  in  WIDTH  one-hot grant from the arbiter (combinational from arb_request).
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat accept.
- out_data  out  DATA_WIDTH  output payload (registered).
- out_last  out  1  output end-of-burst (registered).
- out_sel  out  SEL_W  source channel of the current output beat (registered).

Behaviour:
- States: IDLE, LOCKED. State register `sel` holds the locked channel index.
- Reset values: state=IDLE, sel=0, out_valid=0, out_data=0, out_last=0, out_sel=0. in_ready=0 and arb_request=0 in the reset cycle.
- IDLE:
  - arb_request = in_valid; in_ready = 0.
  - If arb_grant != 0: sel <= index of the set bit, then go to LOCKED.
  - If arb_grant has more than one bit set, the lowest set index wins.
  - If arb_grant == 0: stay in IDLE.
- LOCKED:
  - arb_request = 0. This holds the arbiter's rotation frozen during the burst.
  - in_ready[sel] = !out_valid || out_ready; all other in_ready bits are 0.
- Beat transfer on channel sel (in_valid[sel] && in_ready[sel]):
  - out_data <= in_data[sel]; out_last <= in_last[sel]; out_sel <= sel; out_valid <= 1.
- Output handshake:
  - out_valid is cleared when out_ready is high and no new beat is loaded in the same cycle.
  - Output register is one entry deep: a simultaneous drain and load gives full throughput, 1 beat/cycle.
- Burst end: a transfer with in_last[sel]=1 moves the state to IDLE in the next cycle.
  - The next arbitration runs in that IDLE cycle while the last beat may still sit in the output register.
- Latency:
  - Grant seen in cycle T.
  - First input beat accepted in T+1, at the earliest.
  - out_valid high in T+2.
  - Minimum gap between bursts from different channels: 1 idle input cycle (the arbitration cycle).
- Single-beat burst (in_last=1 on the first beat): LOCKED for exactly one accept cycle.
- Input protocol: inputs hold in_valid/in_data/in_last stable until accepted. in_valid may not drop mid-burst; if it does, the block simply waits in LOCKED.
- out_valid high with out_ready low: out_data, out_last and out_sel stay stable, and in_ready[sel] stays 0.
- rst_n low in any cycle, including mid-burst: all state returns to reset values in the next cycle. A partial burst is dropped, with no flush.

Optional Feature:
- Macro: ARMLEO_BURST_MUX_MAXBURST_EN.
- When defined:
  - Adds parameter MAX_BURST (default 16).
  - Adds output port burst_trunc (1 bit).
  - A beat counter is cleared on entering LOCKED and increments per accepted beat.
  - The MAX_BURST-th accepted beat is forced out with out_last=1 and releases the lock, as if in_last were set.
  - burst_trunc pulses 1 cycle, aligned with that beat's out_valid load, only if the input in_last was 0.
  - The remaining beats of the source burst compete for a new grant.
- When undefined: no counter, no port; bursts are unbounded.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0, arb_request=0, out_valid=0, out_sel=0 throughout.
- Single channel: ch2 sends a 3-beat burst 0xA0,0xA1,0xA2 (last on 0xA2), out_ready=1, grant from the real arbiter -> out_valid at T+2, T+3, T+4 with out_sel=2, data in order, out_last only on 0xA2; state back to IDLE at T+4.
- Contention: ch0 and ch3 both request continuously with 2-beat bursts, arbiter attached -> bursts alternate 0,3,0,3. No interleaving of beats within a burst; 1 bubble input cycle between bursts.
- Backpressure: out_ready toggled 1,0,0,1 during a 4-beat ch1 burst -> out_data stable while stalled; in_ready[1]=0 in stalled cycles; no beat lost or duplicated.
- Mid-burst reset: rst_n low after beat 2 of a 5-beat ch0 burst -> next cycle out_valid=0, IDLE; a subsequent ch1 burst is granted normally.
- With ARMLEO_BURST_MUX_MAXBURST_EN, MAX_BURST=4: a 6-beat ch1 burst -> beat 4 is emitted with out_last=1 and burst_trunc=1; beats 5–6 are emitted as a new 2-beat burst with out_last on beat 6 and burst_trunc=0.
